// File: rtl/disp_pkg.sv
// disp_pkg: shared types and limits for the display countdown logic
package disp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD, EXPIRE} cd_state_t;
  localparam int CD_W = 5;
  localparam int CD_MAX = 31;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler that pulses tick at its terminal count and wraps to 0
module tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  assign tick = en && (cnt == W'(TICK_DIV - 1));
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: start/pause/abort countdown sequencer driving the display digits
module countdown_ctrl
  import disp_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CD_W-1:0] load_val,
  input  logic            pause,
  input  logic            abort,
  output logic [CD_W-1:0] countdown_val,
  output logic            countdown_active,
  output logic            paused,
  output logic            expire
);
  cd_state_t state, state_nxt;
  logic [CD_W-1:0] val_nxt;
  logic active_nxt, paused_nxt, expire_nxt;
  logic counting, go_abort, go_start, en, tick;
  assign counting = (state == RUN) || (state == HOLD);
  // a zero preload while counting cancels just like abort
  assign go_abort = abort || (start && load_val == '0 && counting);
  assign go_start = start && load_val != '0;
  // HOLD with pause released already counts, so each held cycle costs exactly one
  assign en = counting && !pause && !go_abort && !go_start;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (go_abort || go_start),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      countdown_val    <= '0;
      countdown_active <= 1'b0;
      paused           <= 1'b0;
      expire           <= 1'b0;
    end else begin
      state            <= state_nxt;
      countdown_val    <= val_nxt;
      countdown_active <= active_nxt;
      paused           <= paused_nxt;
      expire           <= expire_nxt;
    end
  end
  always_comb begin
    state_nxt = go_abort              ? IDLE :
                go_start              ? RUN :
                !counting             ? IDLE :
                pause                 ? HOLD :
                (tick && countdown_val == CD_W'(1)) ? EXPIRE : RUN;
  end
  always_comb begin
    val_nxt    = go_abort ? '0 :
                 go_start ? load_val :
                 tick     ? ((countdown_val > CD_W'(1)) ? countdown_val - 1'b1 : '0) :
                 countdown_val;
    active_nxt = state_nxt != IDLE;
    paused_nxt = state_nxt == HOLD;
    expire_nxt = state_nxt == EXPIRE;
  end
endmodule
